// File: rtl/draw_point_fb_writer.sv
// Point-draw sink: bounds-checks and linearises (x,y) points, buffers them in a
// small FIFO and writes them into the frame buffer through a waitrequest port.
module draw_point_fb_writer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 17
) (
    input  logic              ul1Clock,
    input  logic              ul1Reset_n,
    input  logic              ul1Update,
    input  logic [8:0]        ul9PosX,
    input  logic [8:0]        ul9PosY,
    input  logic [11:0]       ul12Rgb12Data,
    output logic [ADDR_W-1:0] ulAddr,
    output logic [11:0]       ul12WrData,
    output logic              ul1Write,
    input  logic              ul1WaitRequest,
    output logic              ul1Busy,
    output logic              ul1Overflow,
    output logic [15:0]       ul16DropCount,
    input  logic              ul1ClearStatus,
    output logic              dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 12;

    // Valid/ready contract on the memory side: a write is accepted in a cycle
    // where ul1Write=1 and ul1WaitRequest=0; until then addr/data/write hold.
    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                stage_valid_q, stage_valid_d;
    logic [ADDR_W-1:0]   stage_addr_q, stage_addr_d;
    logic [11:0]         stage_rgb_q, stage_rgb_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [11:0]         wr_data_q, wr_data_d;
    logic                write_q, write_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_q, drop_d;
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];

    logic                oob, oob_drop, ovf_drop;
    logic                fifo_full, fifo_empty, done, push, pop;
    logic [ADDR_W-1:0]   pt_addr;
    logic [ENT_W-1:0]    head;
    logic [16:0]         drop_sum;

    always_comb begin
        oob        = (int'(ul9PosX) >= WIDTH) || (int'(ul9PosY) >= HEIGHT);
        pt_addr    = ADDR_W'(ul9PosY) * ADDR_W'(WIDTH) + ADDR_W'(ul9PosX);
        oob_drop   = ul1Update && oob;
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        done       = write_q && !ul1WaitRequest;
        pop        = !fifo_empty && ((state_q == IDLE) || done);
        // A full FIFO still accepts when the head leaves on the same edge.
        push       = stage_valid_q && (!fifo_full || pop);
        ovf_drop   = stage_valid_q && !push;
        head       = mem_q[rd_ptr_q];

        stage_valid_d = ul1Update && !oob;
        stage_addr_d  = stage_addr_q;
        stage_rgb_d   = stage_rgb_q;
        if (ul1Update && !oob) begin
            stage_addr_d = pt_addr;
            stage_rgb_d  = ul12Rgb12Data;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        if (pop) begin
            addr_d    = head[ENT_W-1:12];
            wr_data_d = head[11:0];
            write_d   = 1'b1;
            state_d   = WRITE;
        end else if (done) begin
            write_d = 1'b0;
            state_d = IDLE;
        end

        drop_sum   = {1'b0, drop_q} + 17'(oob_drop) + 17'(ovf_drop);
        drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d = overflow_q | ovf_drop;
        if (ul1ClearStatus) begin
            drop_d     = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
        if (!ul1Reset_n) begin
            state_q       <= IDLE;
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_rgb_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            addr_q        <= '0;
            wr_data_q     <= '0;
            write_q       <= 1'b0;
            overflow_q    <= 1'b0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            stage_rgb_q   <= stage_rgb_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            addr_q        <= addr_d;
            wr_data_q     <= wr_data_d;
            write_q       <= write_d;
            overflow_q    <= overflow_d;
            drop_q        <= drop_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge ul1Clock) begin
        if (push) mem_q[wr_ptr_q] <= {stage_addr_q, stage_rgb_q};
    end

    assign ulAddr        = addr_q;
    assign ul12WrData    = wr_data_q;
    assign ul1Write      = write_q;
    assign ul1Busy       = stage_valid_q | !fifo_empty | write_q;
    assign ul1Overflow   = overflow_q;
    assign ul16DropCount = drop_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_draw_point_fb_writer.sv
// Directed bench for draw_point_fb_writer: expected writes are queued at issue
// time and a negedge monitor matches every accepted frame-buffer write.
`timescale 1ns/1ps
module tb_draw_point_fb_writer;

    localparam int W = 29;

    logic        clk;
    logic        rst_n;
    logic        update;
    logic [8:0]  posx;
    logic [8:0]  posy;
    logic [11:0] rgb;
    logic [16:0] addr;
    logic [11:0] wr_data;
    logic        write;
    logic        waitreq;
    logic        busy;
    logic        overflow;
    logic [15:0] drop_count;
    logic        clear_status;
    logic        dbg_state;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    draw_point_fb_writer dut (
        .ul1Clock       (clk),
        .ul1Reset_n     (rst_n),
        .ul1Update      (update),
        .ul9PosX        (posx),
        .ul9PosY        (posy),
        .ul12Rgb12Data  (rgb),
        .ulAddr         (addr),
        .ul12WrData     (wr_data),
        .ul1Write       (write),
        .ul1WaitRequest (waitreq),
        .ul1Busy        (busy),
        .ul1Overflow    (overflow),
        .ul16DropCount  (drop_count),
        .ul1ClearStatus (clear_status),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && write && !waitreq) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL write_data: got addr=%0d data=%h expected addr=%0d data=%h",
                             addr, wr_data, e[W-1:12], e[11:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_point(input logic [8:0] x, input logic [8:0] y, input logic [11:0] c);
        @(posedge clk); #1;
        update = 1'b1;
        posx   = x;
        posy   = y;
        rgb    = c;
    endtask

    task automatic end_update();
        @(posedge clk); #1;
        update = 1'b0;
    endtask

    task automatic clear_pulse();
        @(posedge clk); #1;
        clear_status = 1'b1;
        @(posedge clk); #1;
        clear_status = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(busy || exp_q.size() != 0), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; update = 1'b0; posx = '0; posy = '0; rgb = '0;
        waitreq = 1'b0; clear_status = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        check("rst_write", 32'(write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // single point, latency: update driven after edge 0
        exp_q.push_back({17'd645, 12'hABC});
        send_point(9'd5, 9'd2, 12'hABC);
        @(posedge clk); #1 update = 1'b0;
        check("lat_e1_write", 32'(write), 32'd0);
        @(posedge clk); #1;
        check("lat_e2_write", 32'(write), 32'd0);
        @(posedge clk); #1;
        check("lat_e3_write", 32'(write), 32'd1);
        check("lat_e3_addr", 32'(addr), 32'd645);
        check("lat_e3_data", 32'(wr_data), 32'hABC);
        @(posedge clk); #1;
        check("single_write_low", 32'(write), 32'd0);
        check("single_busy_low", 32'(busy), 32'd0);

        // corners and out-of-bounds
        exp_q.push_back({17'd76799, 12'h123});
        exp_q.push_back({17'd0, 12'h456});
        send_point(9'd319, 9'd239, 12'h123);
        send_point(9'd0, 9'd0, 12'h456);
        send_point(9'd320, 9'd0, 12'h789);
        send_point(9'd0, 9'd240, 12'hFED);
        end_update();
        wait_idle("corner_drain", 20);
        check("corner_drop", 32'(drop_count), 32'd2);
        check("corner_overflow", 32'(overflow), 32'd0);

        // long stall then back-to-back follow-up
        clear_pulse();
        check("clear_drop", 32'(drop_count), 32'd0);
        waitreq = 1'b1;
        exp_q.push_back({17'd330, 12'h0A1});
        exp_q.push_back({17'd331, 12'h0B2});
        send_point(9'd10, 9'd1, 12'h0A1);
        send_point(9'd11, 9'd1, 12'h0B2);
        end_update();
        n = 0;
        while (!write && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_start", 32'(write), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall_write", 32'(write), 32'd1);
            check("stall_addr", 32'(addr), 32'd330);
            check("stall_data", 32'(wr_data), 32'h0A1);
        end
        waitreq = 1'b0;
        @(posedge clk); #1;
        check("b2b_write", 32'(write), 32'd1);
        check("b2b_addr", 32'(addr), 32'd331);
        check("b2b_data", 32'(wr_data), 32'h0B2);
        @(posedge clk); #1;
        check("b2b_end", 32'(write), 32'd0);
        wait_idle("stall_drain", 20);

        // overflow: 10 points against a stalled port, released as the last arrives
        waitreq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) exp_q.push_back({17'(960 + i), 12'(256 + i)});
            send_point(9'(i), 9'd3, 12'(256 + i));
        end
        exp_q.push_back({17'd969, 12'h109});
        @(posedge clk); #1;
        update  = 1'b0;
        waitreq = 1'b0;
        wait_idle("ovf_drain", 40);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drop", 32'(drop_count), 32'd4);

        // reset while a write is pending and three entries are queued
        waitreq = 1'b1;
        for (int i = 0; i < 4; i++) send_point(9'(i), 9'd5, 12'h5A0);
        end_update();
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_write", 32'(write), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_write", 32'(write), 32'd0);
        waitreq = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_write", 32'(write), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_overflow", 32'(overflow), 32'd0);
        check("post_rst_drop", 32'(drop_count), 32'd0);
        check("post_rst_addr", 32'(addr), 32'd0);

        // drop counter saturation and clear priority
        @(posedge clk); #1;
        update = 1'b1; posx = 9'd400; posy = 9'd0; rgb = 12'h000;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 32'(drop_count), 32'hFFFE);
        repeat (6) @(posedge clk);
        #1;
        check("sat_ffff", 32'(drop_count), 32'hFFFF);
        clear_status = 1'b1;
        @(posedge clk); #1;
        clear_status = 1'b0;
        update       = 1'b0;
        check("clear_prio_drop", 32'(drop_count), 32'd0);
        check("clear_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
